steer_en_ctrl: RTL and testbench

//  Parametrised rider-presence / steering-enable controller. Successor to the fixed 12-bit steering enable.

---
 rtl/steer_pkg.sv | 20 ++
 rtl/steer_settle_tmr.sv | 41 ++++
 rtl/steer_en_ctrl.sv | 154 +++++++++++++++
 tb/tb_steer_en_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/steer_pkg.sv
// Shared types and default thresholds for the rider-presence / steering-enable path.
// Holds the controller state encoding and the default tuning constants, which the
// balance controller also uses.
package steer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    STEER_EN = 2'd2
  } steer_st_t;

  localparam int unsigned DEF_LD_W         = 12;
  localparam int unsigned DEF_MIN_RIDER_WT = 'h200;
  localparam int unsigned DEF_WT_HYST      = 'h040;
  localparam int unsigned DEF_EN_SHIFT     = 2;
  localparam int unsigned DEF_DIS_SHIFT    = 4;
  localparam int unsigned DEF_TMR_W        = 26;
  localparam int unsigned DEF_OFF_DBNC     = 4;

endpackage

// File: rtl/steer_settle_tmr.sv
// Settle timer for the steering-enable controller.
// Counts while i_inc is high, saturating once full; i_clr has priority and zeroes it.
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   i_clr   in   synchronous clear
//   i_inc   in   count enable
//   o_full  out  timer has reached its full value
module steer_settle_tmr #(
  parameter int unsigned TMR_W    = 26,
  parameter bit          FAST_SIM = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_full
);

  // FAST_SIM shortens "full" to the low 15 bits; since counting stops at full, the
  // upper bits then never become set.
  localparam int unsigned      FULL_BITS = FAST_SIM ? 15 : TMR_W;
  localparam logic [TMR_W-1:0] FULL_MASK = TMR_W'((64'd1 << FULL_BITS) - 64'd1);

  logic [TMR_W-1:0] r_tmr;
  logic             w_full;

  assign w_full = ((r_tmr & FULL_MASK) == FULL_MASK);
  assign o_full = w_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr <= '0;
    end else if (i_clr) begin
      r_tmr <= '0;
    end else if (i_inc && !w_full) begin
      r_tmr <= r_tmr + 1'b1;
    end
  end

endmodule

// File: rtl/steer_en_ctrl.sv
// Rider-presence / steering-enable controller.
// Qualifies left/right load-cell readings into rider-present and balanced flags, and
// enables steering only after the rider has been present and balanced for a settle time.
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   lft_ld     in   left load cell, unsigned
//   rght_ld    in   right load cell, unsigned
//   ld_vld     in   strobe: readings are new this cycle; flags act only then
//   en_steer   out  registered, high only in STEER_EN
//   rider_off  out  registered, high only in IDLE
//   state      out  current controller state
module steer_en_ctrl
  import steer_pkg::*;
#(
  parameter int unsigned LD_W         = DEF_LD_W,
  parameter int unsigned MIN_RIDER_WT = DEF_MIN_RIDER_WT,
  parameter int unsigned WT_HYST      = DEF_WT_HYST,
  parameter int unsigned EN_SHIFT     = DEF_EN_SHIFT,
  parameter int unsigned DIS_SHIFT    = DEF_DIS_SHIFT,
  parameter int unsigned TMR_W        = DEF_TMR_W,
  parameter bit          FAST_SIM     = 1'b0,
  parameter int unsigned OFF_DBNC     = DEF_OFF_DBNC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [LD_W-1:0] lft_ld,
  input  logic [LD_W-1:0] rght_ld,
  input  logic            ld_vld,
  output logic            en_steer,
  output logic            rider_off,
  output steer_st_t       state
);

  localparam logic [LD_W:0] LO_THR = (LD_W + 1)'(MIN_RIDER_WT - WT_HYST);
  localparam logic [LD_W:0] HI_THR = (LD_W + 1)'(MIN_RIDER_WT + WT_HYST);

  localparam int unsigned         DBNC_W   = $clog2(OFF_DBNC + 1);
  localparam logic [DBNC_W-1:0]   DBNC_MAX = DBNC_W'(OFF_DBNC);

  // Load arithmetic, one bit wider than the readings so full scale cannot wrap.
  logic [LD_W:0] w_sum;
  logic [LD_W:0] w_abs_diff;
  logic [LD_W:0] w_en_thr;
  logic [LD_W:0] w_dis_thr;
  logic          w_lt_min;
  logic          w_gt_min;
  logic          w_diff_gt_en;
  logic          w_diff_gt_dis;

  assign w_sum      = {1'b0, lft_ld} + {1'b0, rght_ld};
  assign w_abs_diff = (lft_ld >= rght_ld) ? ({1'b0, lft_ld} - {1'b0, rght_ld})
                                          : ({1'b0, rght_ld} - {1'b0, lft_ld});
  assign w_en_thr   = w_sum >> EN_SHIFT;
  assign w_dis_thr  = w_sum - (w_sum >> DIS_SHIFT);

  assign w_lt_min      = (w_sum < LO_THR);
  assign w_gt_min      = (w_sum > HI_THR);
  assign w_diff_gt_en  = (w_abs_diff > w_en_thr);
  assign w_diff_gt_dis = (w_abs_diff > w_dis_thr);

  steer_st_t         r_state;
  steer_st_t         w_state_d;
  logic [DBNC_W-1:0] r_dbnc;
  logic [DBNC_W-1:0] w_dbnc_d;
  logic [DBNC_W-1:0] w_dbnc_inc;
  logic              w_tmr_clr;
  logic              w_tmr_inc;
  logic              w_tmr_full;
  logic              r_en_steer;
  logic              r_rider_off;

  // Timer runs every clock in WAIT regardless of ld_vld.
  assign w_tmr_inc = (r_state == WAIT);

  steer_settle_tmr #(
    .TMR_W    (TMR_W),
    .FAST_SIM (FAST_SIM)
  ) u_settle_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_tmr_clr),
    .i_inc  (w_tmr_inc),
    .o_full (w_tmr_full)
  );

  always_comb begin
    w_state_d  = r_state;
    w_dbnc_d   = r_dbnc;
    w_dbnc_inc = '0;
    w_tmr_clr  = 1'b0;
    case (r_state)
      IDLE: begin
        w_dbnc_d = '0;
        if (ld_vld && w_gt_min) begin
          w_state_d = WAIT;
          w_tmr_clr = 1'b1;
        end
      end
      WAIT: begin
        w_dbnc_d = '0;
        if (ld_vld) begin
          if (w_lt_min) begin
            w_state_d = IDLE;
          end else if (w_diff_gt_en) begin
            w_tmr_clr = 1'b1;
          end else if (w_tmr_full) begin
            w_state_d = STEER_EN;
          end
        end
      end
      STEER_EN: begin
        if (ld_vld) begin
          // Any valid sample that is not low-weight restarts the debounce.
          w_dbnc_inc = w_lt_min ? (r_dbnc + 1'b1) : '0;
          if (w_dbnc_inc == DBNC_MAX) begin
            w_state_d = IDLE;
            w_dbnc_d  = '0;
          end else if (w_diff_gt_dis) begin
            w_state_d = WAIT;
            w_tmr_clr = 1'b1;
            w_dbnc_d  = '0;
          end else begin
            w_dbnc_d = w_dbnc_inc;
          end
        end
      end
      default: begin
        w_state_d = IDLE;
        w_dbnc_d  = '0;
      end
    endcase
  end

  // Outputs are decoded from next-state so they move on the same edge as state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_dbnc      <= '0;
      r_en_steer  <= 1'b0;
      r_rider_off <= 1'b1;
    end else begin
      r_state     <= w_state_d;
      r_dbnc      <= w_dbnc_d;
      r_en_steer  <= (w_state_d == STEER_EN);
      r_rider_off <= (w_state_d == IDLE);
    end
  end

  assign en_steer  = r_en_steer;
  assign rider_off = r_rider_off;
  assign state     = r_state;

endmodule

// File: tb/tb_steer_en_ctrl.sv
// Self-checking bench for steer_en_ctrl. Two instances share the stimulus: the
// FAST_SIM configuration and a short-timer configuration whose behaviour is quicker to
// exercise. Both are compared against a behavioural model of the controller rules.
module tb_steer_en_ctrl;
  import steer_pkg::*;

  localparam int MIN_WT     = 'h200;
  localparam int HYST       = 'h040;
  localparam int OFF_N      = 4;
  localparam int FULL_FAST  = 'h7FFF;
  localparam int FULL_SHORT = 255;
  localparam int ST_IDLE    = 0;
  localparam int ST_WAIT    = 1;
  localparam int ST_EN      = 2;
  localparam logic [3:0] O_IDLE = 4'b0100;  // {en_steer, rider_off, state}
  localparam logic [3:0] O_WAIT = 4'b0001;
  localparam logic [3:0] O_EN   = 4'b1010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] lft = '0;
  logic [11:0] rght = '0;
  logic        ld_vld = 1'b0;
  logic        en0, off0, en1, off1;
  steer_st_t   st0, st1;
  logic [3:0]  obs0, obs1;

  assign obs0 = {en0, off0, st0};
  assign obs1 = {en1, off1, st1};

  always #5 clk = ~clk;

  steer_en_ctrl #(
    .LD_W(12), .MIN_RIDER_WT('h200), .WT_HYST('h040), .EN_SHIFT(2), .DIS_SHIFT(4),
    .TMR_W(26), .FAST_SIM(1'b1), .OFF_DBNC(4)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .lft_ld(lft), .rght_ld(rght), .ld_vld(ld_vld),
    .en_steer(en0), .rider_off(off0), .state(st0)
  );

  steer_en_ctrl #(
    .LD_W(12), .MIN_RIDER_WT('h200), .WT_HYST('h040), .EN_SHIFT(2), .DIS_SHIFT(4),
    .TMR_W(8), .FAST_SIM(1'b0), .OFF_DBNC(4)
  ) u_dut_short (
    .clk(clk), .rst_n(rst_n), .lft_ld(lft), .rght_ld(rght), .ld_vld(ld_vld),
    .en_steer(en1), .rider_off(off1), .state(st1)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    int st;
    int tmr;
    int dbnc;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mdl_next(input mdl_t m, input int l, input int r, input bit vld,
                                    input int full);
    mdl_t n;
    int   sum;
    int   ad;
    int   d;
    bit   low, high, bad_en, bad_dis;
    n       = m;
    sum     = l + r;
    ad      = (l > r) ? l - r : r - l;
    low     = sum < (MIN_WT - HYST);
    high    = sum > (MIN_WT + HYST);
    bad_en  = ad > sum / 4;
    bad_dis = ad > sum - sum / 16;
    if (m.st == ST_IDLE) begin
      n.dbnc = 0;
      if (vld && high) begin
        n.st  = ST_WAIT;
        n.tmr = 0;
      end
    end else if (m.st == ST_WAIT) begin
      n.tmr = (m.tmr < full) ? m.tmr + 1 : full;
      if (vld && low) n.st = ST_IDLE;
      else if (vld && bad_en) n.tmr = 0;
      else if (vld && m.tmr == full) n.st = ST_EN;
    end else if (vld) begin
      d = low ? m.dbnc + 1 : 0;
      if (d == OFF_N) begin
        n.st   = ST_IDLE;
        n.dbnc = 0;
      end else if (bad_dis) begin
        n.st   = ST_WAIT;
        n.tmr  = 0;
        n.dbnc = 0;
      end else begin
        n.dbnc = d;
      end
    end
    return n;
  endfunction

  function automatic logic [3:0] exp_of(input mdl_t m);
    return {m.st == ST_EN, m.st == ST_IDLE, 2'(m.st)};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= mdl_next(m0, int'(lft), int'(rght), ld_vld, FULL_FAST);
      m1 <= mdl_next(m1, int'(lft), int'(rght), ld_vld, FULL_SHORT);
    end
  end

  // ---------------- stimulus helpers ----------------
  int cyc = 0;
  int vcnt = 0;
  bit last_vld = 1'b0;
  int n_pass = 0;
  int n_tot = 0;

  // One clock; ld_vld is high on every 4th edge. Returns 1 ns after the edge.
  task automatic step();
    ld_vld = (vcnt == 3);
    vcnt   = (vcnt + 1) % 4;
    @(posedge clk);
    last_vld = ld_vld;
    cyc++;
    #1;
  endtask

  task automatic step_to_vld();
    do step(); while (!last_vld);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    lft   = '0;
    rght  = '0;
    repeat (3) step();
    n_tot++;
    if (obs0 !== O_IDLE) $display("FAIL reset_main: got %b want %b", obs0, O_IDLE);
    else n_pass++;
    n_tot++;
    if (obs1 !== O_IDLE) $display("FAIL reset_short: got %b want %b", obs1, O_IDLE);
    else n_pass++;
    rst_n = 1'b1;
    repeat (8) step();
    n_tot++;
    if (obs0 !== O_IDLE) $display("FAIL idle_empty: got %b want %b", obs0, O_IDLE);
    else n_pass++;
  endtask

  task automatic test_enable();
    int c_w;
    lft  = 12'h130;
    rght = 12'h130;
    c_w  = cyc;
    for (int i = 0; i < 8; i++) begin
      step();
      if (st0 == WAIT) begin
        c_w = cyc;
        break;
      end
    end
    n_tot++;
    if (obs0 !== O_WAIT) $display("FAIL enter_wait: got %b want %b", obs0, O_WAIT);
    else n_pass++;
    for (int i = 0; i < 40000 && !en0 && m0.st != ST_EN; i++) step();
    n_tot++;
    if (obs0 !== exp_of(m0)) $display("FAIL enable_model: got %b want %b", obs0, exp_of(m0));
    else n_pass++;
    n_tot++;
    if (obs0 !== O_EN) $display("FAIL enable_state: got %b want %b", obs0, O_EN);
    else n_pass++;
    n_tot++;
    if (cyc - c_w < 'h7FFF || cyc - c_w > 'h8003)
      $display("FAIL enable_delay: got %0d clks want 32767..32771", cyc - c_w);
    else n_pass++;
    n_tot++;
    if (obs1 !== exp_of(m1)) $display("FAIL enable_short: got %b want %b", obs1, exp_of(m1));
    else n_pass++;
  endtask

  task automatic test_debounce_hold();
    for (int r = 0; r < 2; r++) begin
      lft  = 12'h0D8;  // sum 0x1B0, below MIN-HYST
      rght = 12'h0D8;
      repeat (3) step_to_vld();
      n_tot++;
      if (obs0 !== O_EN) $display("FAIL dbnc_hold_low%0d: got %b want %b", r, obs0, O_EN);
      else n_pass++;
      lft  = 12'h130;
      rght = 12'h130;
      step_to_vld();
      n_tot++;
      if (obs0 !== exp_of(m0) || obs0 !== O_EN)
        $display("FAIL dbnc_hold_back%0d: got %b want %b", r, obs0, O_EN);
      else n_pass++;
    end
  endtask

  task automatic test_dis();
    lft  = 12'h2F0;
    rght = 12'h008;
    step_to_vld();
    n_tot++;
    if (obs0 !== O_WAIT) $display("FAIL dis_to_wait: got %b want %b", obs0, O_WAIT);
    else n_pass++;
    n_tot++;
    if (obs1 !== exp_of(m1)) $display("FAIL dis_short: got %b want %b", obs1, exp_of(m1));
    else n_pass++;
  endtask

  task automatic test_restart();
    int c_clr;
    lft  = 12'h200;
    rght = 12'h060;
    repeat (100) step_to_vld();
    c_clr = cyc;
    n_tot++;
    if (obs0 !== O_WAIT) $display("FAIL imbal_hold_wait: got %b want %b", obs0, O_WAIT);
    else n_pass++;
    n_tot++;
    if (obs1 !== O_WAIT) $display("FAIL imbal_short_wait: got %b want %b", obs1, O_WAIT);
    else n_pass++;
    lft  = 12'h130;
    rght = 12'h130;
    for (int i = 0; i < 40000 && !en0 && m0.st != ST_EN; i++) step();
    n_tot++;
    if (obs0 !== O_EN || obs0 !== exp_of(m0))
      $display("FAIL restart_enable: got %b want %b", obs0, O_EN);
    else n_pass++;
    n_tot++;
    if (cyc - c_clr < 'h7FFF || cyc - c_clr > 'h8003)
      $display("FAIL restart_delay: got %0d clks want 32767..32771", cyc - c_clr);
    else n_pass++;
  endtask

  task automatic test_debounce_off();
    logic [3:0] want;
    lft  = 12'h0D8;
    rght = 12'h0D8;
    for (int s = 1; s <= 4; s++) begin
      step_to_vld();
      want = (s < 4) ? O_EN : O_IDLE;
      n_tot++;
      if (obs0 !== want) $display("FAIL dbnc_off_s%0d: got %b want %b", s, obs0, want);
      else n_pass++;
    end
    n_tot++;
    if (obs1 !== exp_of(m1)) $display("FAIL dbnc_off_short: got %b want %b", obs1, exp_of(m1));
    else n_pass++;
  endtask

  task automatic test_full_scale();
    lft  = 12'hFFF;
    rght = 12'h000;
    step_to_vld();
    n_tot++;
    if (obs0 !== O_WAIT) $display("FAIL fs_enter_wait: got %b want %b", obs0, O_WAIT);
    else n_pass++;
    repeat (80) step_to_vld();
    n_tot++;
    if (obs1 !== O_WAIT) $display("FAIL fs_left_hold: got %b want %b", obs1, O_WAIT);
    else n_pass++;
    lft  = 12'h000;
    rght = 12'hFFF;
    repeat (80) step_to_vld();
    n_tot++;
    if (obs1 !== O_WAIT || obs0 !== O_WAIT)
      $display("FAIL fs_right_hold: got %b/%b want %b", obs0, obs1, O_WAIT);
    else n_pass++;
  endtask

  task automatic test_random();
    int hold;
    int base;
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (vcnt == 3) begin
        if (hold == 0) begin
          hold = $urandom_range(1, 100);
          if ($urandom_range(0, 3) != 0) begin
            base = $urandom_range('h080, 'h1A0);
            lft  = 12'(base);
            rght = 12'(base + $urandom_range(0, 'h20));
          end else begin
            lft  = 12'($urandom_range(0, 'hFFF));
            rght = 12'($urandom_range(0, 'hFFF));
          end
        end
        hold--;
      end
      step();
      n_tot++;
      if (obs0 !== exp_of(m0)) $display("FAIL rand_main@%0d: got %b want %b", i, obs0, exp_of(m0));
      else n_pass++;
      n_tot++;
      if (obs1 !== exp_of(m1)) $display("FAIL rand_short@%0d: got %b want %b", i, obs1, exp_of(m1));
      else n_pass++;
      if (n_tot - n_pass > 10) break;
    end
  endtask

  task automatic test_reset_mid();
    lft  = 12'h130;
    rght = 12'h130;
    for (int i = 0; i < 1200 && !en1; i++) step();
    n_tot++;
    if (obs1 !== O_EN) $display("FAIL mid_reach_en: got %b want %b", obs1, O_EN);
    else n_pass++;
    lft  = 12'hFFF;
    rght = 12'h000;
    step_to_vld();
    n_tot++;
    if (obs1 !== O_WAIT) $display("FAIL fs_en_to_wait: got %b want %b", obs1, O_WAIT);
    else n_pass++;
    lft  = 12'h130;
    rght = 12'h130;
    for (int i = 0; i < 1200 && !en1; i++) step();
    n_tot++;
    if (obs1 !== O_EN) $display("FAIL mid_reach_en2: got %b want %b", obs1, O_EN);
    else n_pass++;
    rst_n = 1'b0;  // asynchronous, between clock edges
    #1;
    n_tot++;
    if (obs1 !== O_IDLE) $display("FAIL mid_reset_short: got %b want %b", obs1, O_IDLE);
    else n_pass++;
    n_tot++;
    if (obs0 !== O_IDLE) $display("FAIL mid_reset_main: got %b want %b", obs0, O_IDLE);
    else n_pass++;
    lft  = '0;
    rght = '0;
    repeat (4) step();
    rst_n = 1'b1;
    repeat (8) step();
    n_tot++;
    if (obs1 !== O_IDLE || obs0 !== O_IDLE)
      $display("FAIL post_reset_idle: got %b/%b want %b", obs0, obs1, O_IDLE);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_enable();
    test_debounce_hold();
    test_dis();
    test_restart();
    test_debounce_off();
    test_full_scale();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
